// File: rtl/itlb_cache.sv
// Instruction micro-TLB: a small fully-associative cache of translations
// sitting in front of the main TLB's instruction port. Hits answer in one
// cycle; misses walk the main TLB for one cycle and respond in the next.
module itlb_cache #(
    parameter int N_ENTRIES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  asid,
    input  logic        req_valid,
    input  logic [19:0] req_vpn,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [19:0] resp_pfn,
    output logic        resp_cached,
    output logic        resp_miss,
    output logic        resp_invalid,
    output logic        main_req,
    output logic [31:0] main_vaddr,
    input  logic        main_miss,
    input  logic        main_valid,
    input  logic        main_global,
    input  logic        main_cached,
    input  logic [19:0] main_pfn,
    input  logic        flush
);

    localparam int IDX_W = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WALK,
        FILL
    } state_t;

    state_t state;
    state_t state_next;

    logic [N_ENTRIES-1:0] ent_valid;
    logic [19:0]          ent_vpn    [N_ENTRIES];
    logic [7:0]           ent_asid   [N_ENTRIES];
    logic                 ent_global [N_ENTRIES];
    logic [19:0]          ent_pfn    [N_ENTRIES];
    logic                 ent_cached [N_ENTRIES];

    logic [IDX_W-1:0] rr_ptr;
    logic [19:0]      lat_vpn;
    logic [7:0]       lat_asid;

    logic             hit;
    logic [IDX_W-1:0] hit_idx;
    logic [IDX_W-1:0] vic_idx;
    logic             vic_from_ptr;
    logic             accept;
    logic             lookup_hit;
    logic             do_fill;

    // Associative tag match; the lowest matching index wins if ever several match
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = N_ENTRIES - 1; i >= 0; i--) begin
            if (ent_valid[i] && (ent_vpn[i] == req_vpn) &&
                (ent_global[i] || (ent_asid[i] == asid))) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    // Victim choice: first free slot, otherwise the round-robin pointer
    always_comb begin
        vic_idx      = rr_ptr;
        vic_from_ptr = 1'b1;
        for (int i = N_ENTRIES - 1; i >= 0; i--) begin
            if (!ent_valid[i]) begin
                vic_idx      = IDX_W'(i);
                vic_from_ptr = 1'b0;
            end
        end
    end

    assign accept     = (state == IDLE) && req_valid;
    assign lookup_hit = hit && !flush;
    assign do_fill    = (state == WALK) && !main_miss && main_valid && !flush;

    // Next-state and control outputs; a hit keeps us in IDLE so hits stream
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        main_req   = 1'b0;
        unique case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (accept && !lookup_hit) begin
                    state_next = WALK;
                end
            end
            WALK: begin
                main_req   = 1'b1;
                state_next = FILL;
            end
            FILL: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign main_vaddr = {lat_vpn, 12'h000};

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Capture the missing request so the walk and fill use a stable tag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_vpn  <= '0;
            lat_asid <= '0;
        end else if (accept && !lookup_hit) begin
            lat_vpn  <= req_vpn;
            lat_asid <= asid;
        end
    end

    // Response register: a one-cycle strobe, data forced to zero otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_valid   <= 1'b0;
            resp_pfn     <= '0;
            resp_cached  <= 1'b0;
            resp_miss    <= 1'b0;
            resp_invalid <= 1'b0;
        end else if (accept && lookup_hit) begin
            resp_valid   <= 1'b1;
            resp_pfn     <= ent_pfn[hit_idx];
            resp_cached  <= ent_cached[hit_idx];
            resp_miss    <= 1'b0;
            resp_invalid <= 1'b0;
        end else if (state == WALK) begin
            resp_valid   <= 1'b1;
            resp_pfn     <= main_pfn;
            resp_cached  <= main_cached;
            resp_miss    <= main_miss;
            resp_invalid <= !main_miss && !main_valid;
        end else begin
            resp_valid   <= 1'b0;
            resp_pfn     <= '0;
            resp_cached  <= 1'b0;
            resp_miss    <= 1'b0;
            resp_invalid <= 1'b0;
        end
    end

    // Entry array: flush wins over a fill, and faulting walks are never cached
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ent_valid <= '0;
            for (int i = 0; i < N_ENTRIES; i++) begin
                ent_vpn[i]    <= '0;
                ent_asid[i]   <= '0;
                ent_global[i] <= 1'b0;
                ent_pfn[i]    <= '0;
                ent_cached[i] <= 1'b0;
            end
        end else if (flush) begin
            ent_valid <= '0;
        end else if (do_fill) begin
            ent_valid[vic_idx]  <= 1'b1;
            ent_vpn[vic_idx]    <= lat_vpn;
            ent_asid[vic_idx]   <= lat_asid;
            ent_global[vic_idx] <= main_global;
            ent_pfn[vic_idx]    <= main_pfn;
            ent_cached[vic_idx] <= main_cached;
        end
    end

    // Round-robin pointer only advances when it actually picked the victim
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (do_fill && vic_from_ptr) begin
            rr_ptr <= (rr_ptr == IDX_W'(N_ENTRIES - 1)) ? '0 : rr_ptr + 1'b1;
        end
    end

endmodule

// File: tb/tb_itlb_cache.sv
// Self-checking bench for itlb_cache: a driver issues translation requests
// against an array-based reference model and queues expected responses;
// an independent monitor pops and compares whenever resp_valid is seen.
module tb_itlb_cache;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  asid;
    logic        req_valid;
    logic [19:0] req_vpn;
    logic        req_ready;
    logic        resp_valid;
    logic [19:0] resp_pfn;
    logic        resp_cached;
    logic        resp_miss;
    logic        resp_invalid;
    logic        main_req;
    logic [31:0] main_vaddr;
    logic        main_miss;
    logic        main_valid;
    logic        main_global;
    logic        main_cached;
    logic [19:0] main_pfn;
    logic        flush;

    itlb_cache #(.N_ENTRIES(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .asid         (asid),
        .req_valid    (req_valid),
        .req_vpn      (req_vpn),
        .req_ready    (req_ready),
        .resp_valid   (resp_valid),
        .resp_pfn     (resp_pfn),
        .resp_cached  (resp_cached),
        .resp_miss    (resp_miss),
        .resp_invalid (resp_invalid),
        .main_req     (main_req),
        .main_vaddr   (main_vaddr),
        .main_miss    (main_miss),
        .main_valid   (main_valid),
        .main_global  (main_global),
        .main_cached  (main_cached),
        .main_pfn     (main_pfn),
        .flush        (flush)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [19:0] pfn;
        logic        cached;
        logic        miss;
        logic        invalid;
    } resp_t;

    resp_t exp_q[$];

    int n_vectors     = 0;
    int n_miscompares = 0;

    // Reference model: a plain table of translations plus a replacement cursor
    logic        m_v   [N];
    logic [19:0] m_vpn [N];
    logic [7:0]  m_asid[N];
    logic        m_g   [N];
    logic [19:0] m_pfn [N];
    logic        m_c   [N];
    int          m_ptr;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_vectors++;
        if (actual !== expected) begin
            n_miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic int modelFind(input logic [19:0] v, input logic [7:0] a);
        for (int i = 0; i < N; i++) begin
            if (m_v[i] && m_vpn[i] == v && (m_g[i] || m_asid[i] == a)) return i;
        end
        return -1;
    endfunction

    task automatic modelClear();
        for (int i = 0; i < N; i++) m_v[i] = 1'b0;
    endtask

    task automatic modelFill(input logic [19:0] v, input logic [7:0] a, input logic g,
                             input logic [19:0] p, input logic c);
        int vic;
        vic = -1;
        for (int i = 0; i < N; i++) begin
            if (!m_v[i] && vic < 0) vic = i;
        end
        if (vic < 0) begin
            vic   = m_ptr;
            m_ptr = (m_ptr + 1) % N;
        end
        m_v[vic]    = 1'b1;
        m_vpn[vic]  = v;
        m_asid[vic] = a;
        m_g[vic]    = g;
        m_pfn[vic]  = p;
        m_c[vic]    = c;
    endtask

    // Monitor: every response strobe must match the oldest expectation
    always @(negedge clk) begin : monitor
        resp_t e;
        if (!rst) begin
            if (resp_valid) begin
                if (exp_q.size() == 0) begin
                    checkOutput("resp_unexpected", 32'(resp_valid), 32'(0));
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("resp_pfn",     32'(resp_pfn),     32'(e.pfn));
                    checkOutput("resp_cached",  32'(resp_cached),  32'(e.cached));
                    checkOutput("resp_miss",    32'(resp_miss),    32'(e.miss));
                    checkOutput("resp_invalid", 32'(resp_invalid), 32'(e.invalid));
                end
            end else begin
                checkOutput("resp_idle_zero",
                            32'({resp_pfn, resp_cached, resp_miss, resp_invalid}), 32'(0));
            end
        end
    end

    task automatic idleCycle(input logic f);
        req_valid = 1'b0;
        flush     = f;
        if (f) modelClear();
        @(posedge clk); #1;
        flush = 1'b0;
    endtask

    // One request: model decides hit or miss; miss walks use the given main TLB reply
    task automatic applyStimulus(input logic [19:0] v, input logic [7:0] a, input logic f_idle,
                                 input logic mm, input logic mv, input logic mg, input logic mc,
                                 input logic [19:0] mp, input logic f_walk, input logic f_fill,
                                 input logic abort);
        int idx;
        checkOutput("req_ready_idle", 32'(req_ready), 32'(1));
        req_valid = 1'b1;
        req_vpn   = v;
        asid      = a;
        flush     = f_idle;
        idx = f_idle ? -1 : modelFind(v, a);
        if (f_idle) modelClear();
        @(posedge clk); #1;
        req_valid = 1'b0;
        flush     = 1'b0;
        if (idx >= 0) begin
            exp_q.push_back(resp_t'{m_pfn[idx], m_c[idx], 1'b0, 1'b0});
            checkOutput("main_req_after_hit", 32'(main_req), 32'(0));
            return;
        end
        exp_q.push_back(resp_t'{mp, mc, mm, !mm && !mv});
        checkOutput("main_req_walk",   32'(main_req),  32'(1));
        checkOutput("main_vaddr",      main_vaddr,     {v, 12'h000});
        checkOutput("req_ready_walk",  32'(req_ready), 32'(0));
        if (abort) begin
            rst = 1'b1;
            void'(exp_q.pop_back());
            modelClear();
            m_ptr = 0;
            @(posedge clk); #1;
            rst = 1'b0;
            checkOutput("req_ready_after_rst",  32'(req_ready),  32'(1));
            checkOutput("resp_valid_after_rst", 32'(resp_valid), 32'(0));
            return;
        end
        main_miss   = mm;
        main_valid  = mv;
        main_global = mg;
        main_cached = mc;
        main_pfn    = mp;
        flush       = f_walk;
        @(posedge clk); #1;
        if (!mm && mv && !f_walk) modelFill(v, a, mg, mp, mc);
        if (f_walk) modelClear();
        checkOutput("main_req_fill",  32'(main_req),  32'(0));
        checkOutput("req_ready_fill", 32'(req_ready), 32'(0));
        main_miss   = 1'($urandom);
        main_valid  = 1'($urandom);
        main_global = 1'($urandom);
        main_cached = 1'($urandom);
        main_pfn    = 20'($urandom);
        flush       = f_fill;
        @(posedge clk); #1;
        if (f_fill) modelClear();
        flush = 1'b0;
    endtask

    // Directed scenarios first, then a randomized stream
    initial begin
        logic [19:0] v;
        logic [7:0]  a;
        modelClear();
        m_ptr       = 0;
        rst         = 1'b1;
        asid        = '0;
        req_valid   = 1'b0;
        req_vpn     = '0;
        main_miss   = 1'b0;
        main_valid  = 1'b0;
        main_global = 1'b0;
        main_cached = 1'b0;
        main_pfn    = '0;
        flush       = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        checkOutput("reset_req_ready",  32'(req_ready),  32'(1));
        checkOutput("reset_resp_valid", 32'(resp_valid), 32'(0));
        checkOutput("reset_main_req",   32'(main_req),   32'(0));
        checkOutput("reset_resp_pfn",   32'(resp_pfn),   32'(0));

        // Round-robin wrap: five fills into four entries, fifth evicts entry 0
        for (int i = 0; i < 5; i++)
            applyStimulus(20'h10000 + 20'(i), 8'h01, 0, 0, 1, 0, 1, 20'h30000 + 20'(i), 0, 0, 0);
        applyStimulus(20'h10002, 8'h01, 0, 0, 1, 0, 1, 20'h0dead, 0, 0, 0);
        applyStimulus(20'h10000, 8'h01, 0, 0, 1, 0, 0, 20'h0beef, 0, 0, 0);

        // Cold miss then hit
        applyStimulus(20'h00400, 8'h00, 0, 0, 1, 0, 1, 20'h01234, 0, 0, 0);
        applyStimulus(20'h00400, 8'h00, 0, 0, 1, 0, 0, 20'h0ffff, 0, 0, 0);

        // Refill fault is never cached
        applyStimulus(20'h00777, 8'h00, 0, 1, 0, 0, 0, 20'h00777, 0, 0, 0);
        applyStimulus(20'h00777, 8'h00, 0, 1, 1, 0, 1, 20'h00123, 0, 0, 0);

        // ASID tagging and global entries
        applyStimulus(20'h00888, 8'h05, 0, 0, 1, 0, 1, 20'h0abcd, 0, 0, 0);
        applyStimulus(20'h00888, 8'h06, 0, 0, 0, 0, 0, 20'h00042, 0, 0, 0);
        applyStimulus(20'h00888, 8'h05, 0, 0, 1, 0, 0, 20'h00001, 0, 0, 0);
        applyStimulus(20'h00999, 8'h05, 0, 0, 1, 1, 0, 20'h05555, 0, 0, 0);
        applyStimulus(20'h00999, 8'haa, 0, 0, 1, 0, 1, 20'h00002, 0, 0, 0);

        // Flush during WALK, during FILL, and coincident with an IDLE hit
        applyStimulus(20'h00aaa, 8'h00, 0, 0, 1, 0, 1, 20'h0aaaa, 1, 0, 0);
        applyStimulus(20'h00aaa, 8'h00, 0, 0, 1, 0, 1, 20'h0aaab, 0, 0, 0);
        applyStimulus(20'h00ccc, 8'h00, 0, 0, 1, 0, 1, 20'h0cccc, 0, 1, 0);
        applyStimulus(20'h00ccc, 8'h00, 0, 0, 1, 0, 0, 20'h0cccd, 0, 0, 0);
        applyStimulus(20'h00bbb, 8'h00, 0, 0, 1, 0, 1, 20'h0bbbb, 0, 0, 0);
        applyStimulus(20'h00bbb, 8'h00, 1, 0, 1, 0, 0, 20'h0bbbc, 0, 0, 0);
        applyStimulus(20'h00bbb, 8'h00, 0, 0, 1, 0, 1, 20'h0bbbd, 0, 0, 0);

        // Reset mid-walk aborts; everything misses afterwards
        applyStimulus(20'h00400, 8'h00, 0, 0, 1, 0, 1, 20'h01234, 0, 0, 1);
        applyStimulus(20'h00bbb, 8'h00, 0, 0, 1, 0, 1, 20'h0bbbe, 0, 0, 0);
        applyStimulus(20'h00bbb, 8'h00, 0, 0, 1, 0, 1, 20'h0bbbf, 0, 0, 0);

        // Randomized stream over a small VPN pool so replacement is exercised
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 7) == 0) idleCycle($urandom_range(0, 7) == 0);
            v = 20'h20000 + 20'($urandom_range(0, 11));
            a = 8'($urandom_range(1, 3));
            applyStimulus(v, a, $urandom_range(0, 15) == 0,
                          $urandom_range(0, 7) == 0, $urandom_range(0, 7) != 0,
                          v[0], 1'($urandom), 20'($urandom),
                          $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
                          $urandom_range(0, 49) == 0);
        end

        repeat (3) @(posedge clk);
        #1;
        checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule

// File: doc/itlb_cache.md
ITLB_CACHE -- requirements
Module: itlb_cache

Interface
REQ-001 SHALL have parameter N_ENTRIES, default 4, number of fully-associative micro-TLB entries (power of two, 2..8).
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port asid  input  8  current ASID from cp0.
REQ-005 SHALL have port req_valid  input  1  fetch translation request.
REQ-006 SHALL have port req_vpn  input  20  virtual page number, vaddr[31:12].
REQ-007 SHALL have port req_ready  output  1  request accepted when req_valid && req_ready.
REQ-008 SHALL have port resp_valid  output  1  one-cycle response strobe.
REQ-009 SHALL have ports resp_pfn (output, 20), resp_cached (output, 1), resp_miss (output, 1, TLB refill fault) and resp_invalid (output, 1, TLB invalid fault).
REQ-010 SHALL have port main_req  output  1  lookup strobe to main TLB instruction port.
REQ-011 SHALL have port main_vaddr  output  32  {latched vpn, 12'b0} to main TLB.
REQ-012 SHALL have ports main_miss, main_valid, main_global, main_cached (inputs, 1 each) and main_pfn (input, 20): combinational main TLB response.
REQ-013 SHALL have port flush  input  1  invalidate all entries (driven on TLBWI/TLBWR).

Function
REQ-014 Each entry SHALL hold valid, vpn[19:0], asid[7:0], global, pfn[19:0], cached.
REQ-015 Hit SHALL be: valid && vpn==req_vpn && (global || asid==current asid); at most one entry hits.
REQ-016 FSM states SHALL be IDLE, WALK, FILL; req_ready SHALL be 1 only in IDLE.
REQ-017 IDLE, accepted hit: next cycle resp_valid=1 with hit entry's pfn/cached, resp_miss=resp_invalid=0; FSM stays IDLE; back-to-back hits at one per cycle.
REQ-018 IDLE, accepted miss: latch vpn, go to WALK.
REQ-019 WALK: main_req=1, main_vaddr={latched vpn,12'b0}; main_* sampled into registers at cycle end; go to FILL.
REQ-020 FILL: resp_valid=1 with sampled pfn/cached, resp_miss=main_miss, resp_invalid=!main_miss && !main_valid; go to IDLE.
REQ-021 Miss latency: resp_valid 2 cycles after acceptance; next request accepted 3 cycles after acceptance.
REQ-022 Fill SHALL occur at end of WALK only if !main_miss && main_valid && no flush in WALK; faulting translations SHALL never be cached.
REQ-023 Victim SHALL be the lowest-index invalid entry if any, else entry at round-robin pointer; pointer SHALL increment (wrapping N_ENTRIES-1 -> 0) only when it selected the victim.
REQ-024 flush SHALL clear all valid bits at the next edge; pointer unchanged.
REQ-025 flush coincident with IDLE request SHALL force a miss (flush priority over hit).
REQ-026 flush during WALK or FILL SHALL suppress that fill; the response is still delivered.
REQ-027 main_req SHALL be 0 outside WALK; resp_* SHALL be 0 when resp_valid=0.
REQ-028 asid change SHALL need no flush; entries tagged by asid.

Reset
REQ-029 On rst: all valid=0, pointer=0, state=IDLE, resp_valid=0, main_req=0, resp_* data=0; req_ready=1 on first cycle after rst deasserts.
REQ-030 rst asserted in WALK/FILL SHALL abort without response or fill.

Verification
REQ-031 Cold request vpn 0x00400, main returns pfn 0x01234 valid cached -> main_req cycle 1, resp_valid cycle 2 pfn 0x01234; same vpn again -> resp_valid next cycle, main_req stays 0.
REQ-032 Request with main_miss=1 -> resp_miss=1 cycle 2; repeat request -> main_req again (not cached).
REQ-033 Fill 5 distinct vpns with N_ENTRIES=4 -> fifth fill replaces entry 0; pointer wraps to 1; first vpn then misses.
REQ-034 Entry with global=0 asid 0x05; request under asid 0x06 -> miss; global=1 entry -> hit under any asid.
REQ-035 flush asserted during WALK -> response delivered, following identical request misses again.
REQ-036 rst asserted mid-WALK -> no resp_valid, req_ready=1 after release, all lookups miss.
